// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with 2-entry skid buffer and BEQ/BNE redirect.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          EX-side handshake (in_ready registered, = !skid valid)
//   alu_out, alu_zero          ALU result and zero flag
//   store_data, target_pc, rd  store value, branch target, destination register
//   ctl                        {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne}
//   flush                      synchronous kill of buffered and incoming entries
//   out_valid/out_ready        MEM-side handshake
//   out_alu/out_store/out_rd/out_ctl  head entry fields
//   redirect, redirect_pc      one-cycle taken-branch pulse and its target
// Optional (EX_MEM_FWD_EN): fwd_rs1, fwd_rs2 -> fwd_hit_a, fwd_hit_b, fwd_data
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_zero,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [DATA_W-1:0]     target_pc,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [5:0]            ctl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_store,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [5:0]            out_ctl,
    output logic                  redirect,
    output logic [DATA_W-1:0]     redirect_pc
`ifdef EX_MEM_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_rs1,
    input  logic [REG_ADDR_W-1:0] fwd_rs2,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [DATA_W-1:0]     fwd_data
`endif
);
    localparam int EW = 6 + REG_ADDR_W + 2 * DATA_W;
    logic [EW-1:0] head, skid, cap;
    logic          head_v, skid_v, acc, dlv, take;
    // Writes to x0 are dropped at capture so MEM/WB never see them.
    assign cap       = {ctl[5] && (rd != '0), ctl[4:0], rd, store_data, alu_out};
    assign in_ready  = !skid_v;
    assign out_valid = head_v;
    assign acc       = in_valid && in_ready;
    assign dlv       = head_v && out_ready;
    assign take      = acc && !flush && ctl[1] && (alu_zero ^ ctl[0]);
    assign {out_ctl, out_rd, out_store, out_alu} = head;
    // in_ready == !skid_v, so an accept never coincides with a full skid;
    // when the head frees up the skid (if any) is always the older entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            skid        <= '0;
            head_v      <= 1'b0;
            skid_v      <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= take;
            if (take) redirect_pc <= target_pc;
            if (flush) begin
                head_v <= 1'b0;
                skid_v <= 1'b0;
            end else if (!head_v || dlv) begin
                head_v <= skid_v || acc;
                if (skid_v) head <= skid;
                else if (acc) head <= cap;
                skid_v <= 1'b0;
            end else if (acc) begin
                skid   <= cap;
                skid_v <= 1'b1;
            end
        end
    end
`ifdef EX_MEM_FWD_EN
    // Loads (mem_to_reg) are not forwardable from this stage.
    assign fwd_hit_a = !flush && head_v && out_ctl[5] && !out_ctl[2] && (fwd_rs1 == out_rd);
    assign fwd_hit_b = !flush && head_v && out_ctl[5] && !out_ctl[2] && (fwd_rs2 == out_rd);
    assign fwd_data  = out_alu;
`endif
endmodule
